pipeline_ctrl: RTL and testbench

Central stall/flush controller for the five-stage MIPS pipeline. It watches decode-stage source registers, the EX-stage load, the MEM-stage branch decision and the data-memory handshake. It drives per-stage enable and flush strobes to the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. A small state machine handles multi-cycle data-memory accesses with a timeout trap.

---
 rtl/pipeline_ctrl.sv | 155 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the five-stage MIPS pipeline, with a multi-cycle data-memory wait FSM and timeout trap.
// Optional performance counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipeline_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        EX_memread,
  input  logic [4:0]  EX_writereg,
  input  logic        MEM_pcsrc,
  input  logic        MEM_memreq,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        memwb_flush,
  output logic        mem_err,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  localparam logic [8:0] TMO = 9'(MEM_TIMEOUT);

  state_t     state, state_nxt;
  logic [7:0] wcnt, wcnt_nxt;
  logic [8:0] wcnt_inc;
  logic       load_use;

  assign load_use = EX_memread && (EX_writereg != 5'd0) &&
                    ((EX_writereg == ID_rs) || (EX_writereg == ID_rt));
  assign wcnt_inc = {1'b0, wcnt} + 9'd1;

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    mem_err     = 1'b0;
    state_nxt   = state;
    wcnt_nxt    = wcnt;

    if (rst) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
      state_nxt   = RUN;
      wcnt_nxt    = 8'd0;
    end else begin
      unique case (state)
        RUN, MEM_WAIT: begin
          if (!mem_ready && (state == MEM_WAIT || MEM_memreq)) begin
            // Freeze upstream stages and drain a bubble into MEM/WB.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
            if (state == RUN) begin
              state_nxt = MEM_WAIT;
              wcnt_nxt  = 8'd1;
            end else begin
              wcnt_nxt = wcnt_inc[7:0];
              // wcnt_inc is the number of freeze cycles completed so far.
              if (wcnt_inc >= TMO) state_nxt = ERR;
            end
          end else begin
            state_nxt = RUN;
            wcnt_nxt  = 8'd0;
            if (MEM_pcsrc) begin
              ifid_flush  = 1'b1;
              idex_flush  = 1'b1;
              exmem_flush = 1'b1;
            end else if (load_use) begin
              pc_en      = 1'b0;
              ifid_en    = 1'b0;
              idex_flush = 1'b1;
            end
          end
        end
        ERR: begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_en     = 1'b0;
          exmem_en    = 1'b0;
          memwb_en    = 1'b0;
          memwb_flush = 1'b1;
          mem_err     = 1'b1;
        end
        default: begin
          state_nxt = RUN;
          wcnt_nxt  = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      wcnt  <= 8'd0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 16'd0;
      flush_q <= 16'd0;
    end else begin
      if (!pc_en)     stall_q <= sat_inc(stall_q);
      if (ifid_flush) flush_q <= sat_inc(flush_q);
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = 16'd0;
  assign flush_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: table vectors, hand sequences and random stimulus
// against a behavioural model; a second instance uses MEM_TIMEOUT=3.
module tb_pipeline_ctrl;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       memread;
    logic [4:0] wreg;
    logic       pcsrc;
    logic       memreq;
    logic       ready;
  } in_t;

  typedef struct {
    in_t         in;
    logic [9:0]  exp;
    string       name;
  } vec_t;

  // {pc,ifid,idex,exmem,memwb en | ifid,idex,exmem,memwb flush | mem_err}
  localparam logic [9:0] O_IDLE  = 10'b11111_0000_0;
  localparam logic [9:0] O_LU    = 10'b00111_0100_0;
  localparam logic [9:0] O_BR    = 10'b11111_1110_0;
  localparam logic [9:0] O_FRZ   = 10'b00001_0001_0;
  localparam logic [9:0] O_RST   = 10'b00000_1111_0;
  localparam logic [9:0] O_ERR   = 10'b00000_0001_1;

`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  in_t drv;
  logic pc_a, ifid_a, idex_a, exmem_a, memwb_a, fifid_a, fidex_a, fexmem_a, fmemwb_a, err_a;
  logic pc_b, ifid_b, idex_b, exmem_b, memwb_b, fifid_b, fidex_b, fexmem_b, fmemwb_b, err_b;
  logic [15:0] sc_a, fc_a, sc_b, fc_b;
  logic [9:0] o_a, o_b;

  assign o_a = {pc_a, ifid_a, idex_a, exmem_a, memwb_a, fifid_a, fidex_a, fexmem_a, fmemwb_a, err_a};
  assign o_b = {pc_b, ifid_b, idex_b, exmem_b, memwb_b, fifid_b, fidex_b, fexmem_b, fmemwb_b, err_b};

  pipeline_ctrl dut (
    .clk(clk), .rst(drv.rst), .ID_rs(drv.rs), .ID_rt(drv.rt), .EX_memread(drv.memread),
    .EX_writereg(drv.wreg), .MEM_pcsrc(drv.pcsrc), .MEM_memreq(drv.memreq), .mem_ready(drv.ready),
    .pc_en(pc_a), .ifid_en(ifid_a), .idex_en(idex_a), .exmem_en(exmem_a), .memwb_en(memwb_a),
    .ifid_flush(fifid_a), .idex_flush(fidex_a), .exmem_flush(fexmem_a), .memwb_flush(fmemwb_a),
    .mem_err(err_a), .stall_cnt(sc_a), .flush_cnt(fc_a)
  );

  pipeline_ctrl #(.MEM_TIMEOUT(3)) dut_t (
    .clk(clk), .rst(drv.rst), .ID_rs(drv.rs), .ID_rt(drv.rt), .EX_memread(drv.memread),
    .EX_writereg(drv.wreg), .MEM_pcsrc(drv.pcsrc), .MEM_memreq(drv.memreq), .mem_ready(drv.ready),
    .pc_en(pc_b), .ifid_en(ifid_b), .idex_en(idex_b), .exmem_en(exmem_b), .memwb_en(memwb_b),
    .ifid_flush(fifid_b), .idex_flush(fidex_b), .exmem_flush(fexmem_b), .memwb_flush(fmemwb_b),
    .mem_err(err_b), .stall_cnt(sc_b), .flush_cnt(fc_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state per instance: freeze cycles spent on the pending access, error latch, counters.
  int frz_a = 0, frz_b = 0;
  bit er_a = 0, er_b = 0;
  int st_a = 0, fl_a = 0, st_b = 0, fl_b = 0;

  function automatic in_t mk(bit r, int rs, int rt, bit mr, int wr, bit pc, bit mq, bit rd);
    in_t v;
    v.rst = r; v.rs = 5'(rs); v.rt = 5'(rt); v.memread = mr; v.wreg = 5'(wr);
    v.pcsrc = pc; v.memreq = mq; v.ready = rd;
    return v;
  endfunction

  function automatic logic [9:0] model_out(in_t v, int frozen, bit err);
    bit lu;
    if (v.rst) return O_RST;
    if (err) return O_ERR;
    if (!v.ready && (frozen > 0 || v.memreq)) return O_FRZ;
    lu = v.memread && v.wreg != 0 && (v.wreg == v.rs || v.wreg == v.rt);
    if (v.pcsrc) return O_BR;
    if (lu) return O_LU;
    return O_IDLE;
  endfunction

  task automatic model_step(input in_t v, input int tmo, inout int frozen, inout bit err,
                            inout int st, inout int fl);
    logic [9:0] o;
    o = model_out(v, frozen, err);
    if (v.rst) begin
      frozen = 0; err = 0; st = 0; fl = 0;
    end else begin
      if (!o[9] && st < 65535) st++;
      if (o[4] && fl < 65535) fl++;
      if (!err) begin
        if (!v.ready && (frozen > 0 || v.memreq)) begin
          frozen++;
          if (frozen >= tmo) err = 1;
        end else begin
          frozen = 0;
        end
      end
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // which: 0 = default instance, 1 = MEM_TIMEOUT=3 instance; hv enables the explicit expectation.
  task automatic run_cycle(input in_t v, input string name, input bit hv, input logic [9:0] hexp,
                           input bit which);
    drv = v;
    #2;
    if (hv) check({name, "/explicit"}, which ? 32'(o_b) : 32'(o_a), 32'(hexp));
    check({name, "/model_a"}, 32'(o_a), 32'(model_out(v, frz_a, er_a)));
    check({name, "/model_b"}, 32'(o_b), 32'(model_out(v, frz_b, er_b)));
    check({name, "/cnt_a"}, {sc_a, fc_a}, PERF ? {16'(st_a), 16'(fl_a)} : 32'd0);
    check({name, "/cnt_b"}, {sc_b, fc_b}, PERF ? {16'(st_b), 16'(fl_b)} : 32'd0);
    model_step(v, 15, frz_a, er_a, st_a, fl_a);
    model_step(v, 3, frz_b, er_b, st_b, fl_b);
    @(posedge clk);
    #1;
  endtask

  function automatic in_t rnd_in(bit allow_rst);
    in_t v;
    v.rst     = allow_rst && ($urandom_range(63) == 0);
    v.rs      = 5'($urandom_range(3));
    v.rt      = 5'($urandom_range(3));
    v.memread = ($urandom_range(2) == 0);
    v.wreg    = 5'($urandom_range(3));
    v.pcsrc   = ($urandom_range(7) == 0);
    v.memreq  = ($urandom_range(3) == 0);
    v.ready   = $urandom_range(1) == 1;
    return v;
  endfunction

  vec_t tbl[9];
  in_t  idle, rstv;

  initial begin
    idle = mk(0, 1, 2, 0, 0, 0, 0, 0);
    rstv = mk(1, 0, 0, 0, 0, 0, 0, 0);
    tbl[0] = '{mk(0, 1, 5, 1, 5, 0, 0, 0), O_LU,   "lu_rt"};
    tbl[1] = '{mk(0, 5, 2, 1, 5, 0, 0, 0), O_LU,   "lu_rs"};
    tbl[2] = '{mk(0, 0, 0, 1, 0, 0, 0, 0), O_IDLE, "lu_r0"};
    tbl[3] = '{mk(0, 1, 5, 0, 5, 0, 0, 0), O_IDLE, "no_load"};
    tbl[4] = '{mk(0, 1, 2, 1, 5, 0, 0, 0), O_IDLE, "no_match"};
    tbl[5] = '{mk(0, 1, 2, 0, 0, 1, 0, 0), O_BR,   "branch"};
    tbl[6] = '{mk(0, 1, 5, 1, 5, 1, 0, 0), O_BR,   "branch_lu"};
    tbl[7] = '{mk(0, 1, 2, 0, 0, 0, 1, 1), O_IDLE, "mem_zero_wait"};
    tbl[8] = '{mk(0, 3, 7, 1, 7, 0, 1, 1), O_LU,   "mem_ready_lu"};

    drv = rstv;
    @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++) begin
      in_t v;
      v = rnd_in(0);
      v.rst = 1;
      run_cycle(v, "reset", 1, O_RST, 0);
    end
    run_cycle(idle, "after_reset", 1, O_IDLE, 0);

    for (int i = 0; i < 9; i++) begin
      run_cycle(tbl[i].in, tbl[i].name, 1, tbl[i].exp, 0);
      run_cycle(idle, {tbl[i].name, "_next"}, 1, O_IDLE, 0);
    end

    for (int i = 0; i < 4; i++) run_cycle(mk(0, 1, 2, 0, 0, 0, 1, 0), "memwait_freeze", 1, O_FRZ, 0);
    run_cycle(mk(0, 1, 2, 0, 0, 0, 1, 1), "memwait_release", 1, O_IDLE, 0);
    run_cycle(idle, "memwait_run", 1, O_IDLE, 0);
    run_cycle(rstv, "rst_mid", 1, O_RST, 0);

    for (int i = 0; i < 2; i++) run_cycle(mk(0, 1, 2, 0, 0, 1, 1, 0), "wait_br_freeze", 1, O_FRZ, 0);
    run_cycle(mk(0, 1, 2, 0, 0, 1, 0, 1), "release_branch", 1, O_BR, 0);
    run_cycle(idle, "release_branch_next", 1, O_IDLE, 0);

    run_cycle(rstv, "tmo_reset", 1, O_RST, 1);
    for (int i = 1; i <= 6; i++)
      run_cycle(mk(0, 1, 2, 0, 0, 0, 1, 0), $sformatf("tmo_c%0d", i), 1, (i >= 4) ? O_ERR : O_FRZ, 1);
    for (int i = 0; i < 2; i++)
      run_cycle(mk(0, 1, 5, 1, 5, 1, 1, 1), "tmo_sticky", 1, O_ERR, 1);
    run_cycle(rstv, "tmo_clear", 1, O_RST, 1);
    run_cycle(idle, "tmo_after", 1, O_IDLE, 1);

    for (int i = 0; i < 3000; i++) run_cycle(rnd_in(1), "random", 0, O_IDLE, 0);

    run_cycle(rstv, "cnt_reset", 1, O_RST, 0);
    run_cycle(idle, "cnt_idle", 0, O_IDLE, 0);
    run_cycle(mk(0, 1, 5, 1, 5, 0, 0, 0), "cnt_lu1", 0, O_IDLE, 0);
    run_cycle(idle, "cnt_idle", 0, O_IDLE, 0);
    run_cycle(mk(0, 4, 2, 1, 4, 0, 0, 0), "cnt_lu2", 0, O_IDLE, 0);
    run_cycle(mk(0, 1, 2, 0, 0, 1, 0, 0), "cnt_br", 0, O_IDLE, 0);
    run_cycle(idle, "cnt_final", 0, O_IDLE, 0);
    check("counters", {sc_a, fc_a}, PERF ? {16'd2, 16'd1} : 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
